// File: rtl/timetag_pkg.sv
// Shared types and constants for the time-tag record path: record/entry/word widths,
// flag bit positions and the serializer state encoding.
package timetag_pkg;

  localparam int REC_W   = 47;
  localparam int ENTRY_W = 48;
  localparam int WORD_W  = 16;
  localparam int WORDS_PER_ENTRY = ENTRY_W / WORD_W;

  // Flag positions inside a stored entry; in word 2 they land at bits 15, 14, 13.
  localparam int LOST_BIT = 47;
  localparam int WRAP_BIT = 46;
  localparam int TYPE_BIT = 45;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    W0   = 2'd1,
    W1   = 2'd2,
    W2   = 2'd3
  } ser_state_e;

  // Debug view of the packer: serializer state plus the flags of the record in flight.
  typedef struct packed {
    ser_state_e state;
    logic       lost_pending;
    logic       hold_lost;
    logic       hold_wrap;
    logic       hold_type;
  } packer_dbg_t;

  function automatic logic [ENTRY_W-1:0] make_entry(input logic lost,
                                                    input logic [REC_W-1:0] rec);
    logic [ENTRY_W-1:0] e;
    e = {1'b0, rec};
    e[LOST_BIT] = lost;
    return e;
  endfunction

  // Word presented on the output for a given serializer state; zero when idle.
  function automatic logic [WORD_W-1:0] entry_word(input logic [ENTRY_W-1:0] e,
                                                   input ser_state_e s);
    logic [WORD_W-1:0] w;
    w = '0;
    case (s)
      W0:      w = e[WORD_W-1:0];
      W1:      w = e[2*WORD_W-1:WORD_W];
      W2:      w = e[3*WORD_W-1:2*WORD_W];
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/record_fifo.sv
// Single-clock FIFO of packed records: registered write, combinational head read,
// full/empty/level status. A write while full is accepted only alongside a read.
module record_fifo
  import timetag_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = ENTRY_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_L = (DEPTH_LOG2+1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  do_wr;
  logic                  do_rd;

  assign full    = (count == DEPTH_LOG2'(0) + DEPTH_L);
  assign empty   = (count == '0);
  assign level   = count;
  assign rd_data = mem[rd_ptr];

  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  // Storage carries no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/record_packer.sv
// Buffers 47-bit time-tag records and sends each as three 16-bit words over valid/ack,
// dropping and counting records that arrive while the buffer is full.
module record_packer
  import timetag_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int LOST_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REC_W-1:0]     rec_data,
  input  logic                 rec_ready,
  output logic [WORD_W-1:0]    word_out,
  output logic                 word_valid,
  input  logic                 word_ack,
  output logic [LOST_W-1:0]    lost_count,
  output logic [DEPTH_LOG2:0]  fifo_level,
  output packer_dbg_t          dbg
);

  // Handshake: a word moves on any cycle with word_valid & word_ack; word_valid and
  // word_out depend only on registered state, so word_out is stable until that cycle.

  ser_state_e         state;
  ser_state_e         state_nxt;
  logic [ENTRY_W-1:0] hold;
  logic [ENTRY_W-1:0] fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               transfer;
  logic               wr_en;
  logic               drop;
  logic               lost_pending;

  assign transfer = word_valid & word_ack;

  // A pop frees a slot this cycle, so a record arriving on a full FIFO still fits.
  assign wr_en = rec_ready & (~fifo_full | pop);
  assign drop  = rec_ready & fifo_full & ~pop;

  record_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (make_entry(lost_pending, rec_data)),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = W0;
        end
      end
      W0: begin
        if (transfer) begin
          state_nxt = W1;
        end
      end
      W1: begin
        if (transfer) begin
          state_nxt = W2;
        end
      end
      W2: begin
        if (transfer) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = W0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      hold  <= '0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        hold <= fifo_head;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lost_pending <= 1'b0;
      lost_count   <= '0;
    end else begin
      if (wr_en) begin
        lost_pending <= 1'b0;
      end else if (drop) begin
        lost_pending <= 1'b1;
      end
      if (drop && (lost_count != '1)) begin
        lost_count <= lost_count + 1'b1;
      end
    end
  end

  assign word_valid = (state != IDLE);
  assign word_out   = entry_word(hold, state);

  assign dbg.state        = state;
  assign dbg.lost_pending = lost_pending;
  assign dbg.hold_lost    = hold[LOST_BIT];
  assign dbg.hold_wrap    = hold[WRAP_BIT];
  assign dbg.hold_type    = hold[TYPE_BIT];

endmodule

// File: tb/tb_record_packer.sv
// Directed bench for record_packer: single record, back-to-back, overflow/lost flag,
// backpressure, full-with-pop and asynchronous reset mid-record.
module tb_record_packer;
  import timetag_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [46:0] rec_data;
  logic        rec_ready;
  logic [15:0] word_out;
  logic        word_valid;
  logic        word_ack;
  logic [15:0] lost_count;
  logic [4:0]  fifo_level;
  packer_dbg_t dbg;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  record_packer #(
    .DEPTH_LOG2 (4),
    .LOST_W     (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rec_data   (rec_data),
    .rec_ready  (rec_ready),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ack   (word_ack),
    .lost_count (lost_count),
    .fifo_level (fifo_level),
    .dbg        (dbg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    rec_ready = 1'b0;
    rec_data  = 'x;
  endtask

  task automatic send(input logic [46:0] rec);
    rec_ready = 1'b1;
    rec_data  = rec;
  endtask

  // Consumes exp_q one word per cycle with word_ack held high.
  task automatic drain_check(input string tag);
    logic [15:0] w;
    while (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      check({tag, "_valid"}, 48'(word_valid), 48'd1);
      check({tag, "_word"}, 48'(word_out), 48'(w));
      tick();
    end
  endtask

  initial begin
    logic [15:0] w2 [9];
    logic [15:0] cw [3];
    logic        pat [4];
    int          peak;
    int          idx;

    reset     = 1'b1;
    word_ack  = 1'b0;
    idle_in();
    repeat (2) tick();

    check("rst_valid", 48'(word_valid), 48'd0);
    check("rst_word",  48'(word_out),   48'd0);
    check("rst_lost",  48'(lost_count), 48'd0);
    check("rst_level", 48'(fifo_level), 48'd0);
    check("rst_state", 48'(dbg.state),  48'(IDLE));
    reset = 1'b0;
    tick();

    // Single record: words appear two cycles after the strobe.
    word_ack = 1'b1;
    send(47'h0_0012_3456_789A);
    check("t1_n0_valid", 48'(word_valid), 48'd0);
    tick();
    idle_in();
    check("t1_n1_valid", 48'(word_valid), 48'd0);
    check("t1_n1_level", 48'(fifo_level), 48'd1);
    tick();
    exp_q = '{16'h789A, 16'h3456, 16'h0012};
    drain_check("t1");
    check("t1_end_valid", 48'(word_valid), 48'd0);

    // Back-to-back records: nine contiguous transfers.
    w2 = '{16'h2222, 16'h1111, 16'h5A5A, 16'h4444, 16'h3333, 16'h6BCD,
           16'h6666, 16'h5555, 16'h7FFF};
    peak = 0;
    for (int c = 0; c < 11; c++) begin
      case (c)
        0:       send(47'h5A5A_1111_2222);
        1:       send(47'h6BCD_3333_4444);
        2:       send(47'h7FFF_5555_6666);
        default: idle_in();
      endcase
      if (c >= 2) begin
        check("t2_valid", 48'(word_valid), 48'd1);
        check("t2_word",  48'(word_out),   48'(w2[c-2]));
      end
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
      tick();
    end
    check("t2_end_valid", 48'(word_valid), 48'd0);
    check("t2_peak", 48'(peak), 48'd2);

    // Overflow: 20 records with no ack; one in the holding register, 16 stored, 3 dropped.
    word_ack = 1'b0;
    for (int k = 0; k < 20; k++) begin
      send({15'(k + 'h0100), 16'(k + 'hA000), 16'(k + 'hB000)});
      tick();
    end
    idle_in();
    tick();
    check("t3_level", 48'(fifo_level), 48'd16);
    check("t3_lost",  48'(lost_count), 48'd3);
    check("t3_word0", 48'(word_out),   48'h0000_0000_B000);
    for (int k = 0; k < 17; k++) begin
      exp_q.push_back(16'(k + 'hB000));
      exp_q.push_back(16'(k + 'hA000));
      exp_q.push_back(16'(k + 'h0100));
    end
    word_ack = 1'b1;
    drain_check("t3_drain");
    check("t3_drained_valid", 48'(word_valid), 48'd0);
    check("t3_drained_level", 48'(fifo_level), 48'd0);
    check("t3_drained_lost",  48'(lost_count), 48'd3);
    send(47'h0ABC_0000_0001);
    tick();
    send(47'h0DEF_0000_0002);
    tick();
    idle_in();
    exp_q = '{16'h0001, 16'h0000, 16'h8ABC, 16'h0002, 16'h0000, 16'h0DEF};
    drain_check("t3_lostflag");

    // Backpressure with ack pattern 1,0,0,1; ack before the first word is ignored.
    cw  = '{16'hACE0, 16'h2468, 16'h1357};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    send(47'h1357_2468_ACE0);
    tick();
    idle_in();
    tick();
    idx = 0;
    for (int k = 0; k < 20 && idx < 3; k++) begin
      word_ack = pat[k % 4];
      check("t4_valid", 48'(word_valid), 48'd1);
      check("t4_word",  48'(word_out),   48'(cw[idx]));
      if (word_ack) idx++;
      tick();
    end
    check("t4_count", 48'(idx), 48'd3);
    check("t4_end_valid", 48'(word_valid), 48'd0);

    // Full FIFO: a record coinciding with the W2 pop is accepted, otherwise dropped.
    word_ack = 1'b0;
    for (int k = 0; k < 17; k++) begin
      send({15'(k + 'h0200), 16'(k + 'hC000), 16'(k + 'hD000)});
      tick();
    end
    idle_in();
    check("t5_full_level", 48'(fifo_level), 48'd16);
    check("t5_full_lost",  48'(lost_count), 48'd3);
    word_ack = 1'b1;
    check("t5_w0", 48'(word_out), 48'h0000_0000_D000);
    tick();
    check("t5_w1", 48'(word_out), 48'h0000_0000_C000);
    tick();
    check("t5_w2", 48'(word_out), 48'h0000_0000_0200);
    send(47'h0777_0000_0777);
    tick();
    idle_in();
    check("t5_pop_level", 48'(fifo_level), 48'd16);
    check("t5_pop_lost",  48'(lost_count), 48'd3);
    check("t5_next_word", 48'(word_out),   48'h0000_0000_D001);
    word_ack = 1'b0;
    send(47'h0111_0000_0111);
    tick();
    idle_in();
    check("t5_drop_lost",  48'(lost_count), 48'd4);
    check("t5_drop_level", 48'(fifo_level), 48'd16);
    word_ack = 1'b1;
    tick();
    word_ack = 1'b0;
    check("t6_pre_state", 48'(dbg.state), 48'(W1));
    check("t6_pre_word",  48'(word_out),  48'h0000_0000_C001);

    // Asynchronous reset in W1, checked before any clock edge.
    reset = 1'b1;
    #1;
    check("t6_async_valid", 48'(word_valid), 48'd0);
    check("t6_async_word",  48'(word_out),   48'd0);
    check("t6_async_level", 48'(fifo_level), 48'd0);
    check("t6_async_lost",  48'(lost_count), 48'd0);
    #1;
    reset = 1'b0;
    word_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t6_post_valid", 48'(word_valid), 48'd0);
      check("t6_post_level", 48'(fifo_level), 48'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
